// File: rtl/load_store_unit.sv
// load_store_unit: single-port memory access sequencer for RV32 loads/stores.
// Generates byte-lane enables and replicated store data, extends load data,
// and aborts with err on illegal funct3, bus timeout or (optionally) misalignment.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses).
module load_store_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic          st_q;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q;
  logic [CW-1:0] cnt;

  logic          legal_c;
  logic          misal_c;
  logic [3:0]    st_be_c;
  logic [31:0]   st_wdata_c;

  // Select and extend the addressed byte/half of a read word.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Legal funct3 encodings for the requested direction.
  always_comb begin
    legal_c = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal_c = 1'b1;
      3'b100, 3'b101:         legal_c = !is_store;
      default:                legal_c = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  assign misal_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misal_c = 1'b0;
`endif

  // Store lane enables and lane-replicated write data.
  always_comb begin
    st_be_c    = 4'b1111;
    st_wdata_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        st_be_c    = 4'b0001 << addr[1:0];
        st_wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be_c    = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata_c = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Access sequencer: state, bus outputs and completion status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      st_q      <= 1'b0;
      f3_q      <= 3'd0;
      lo_q      <= 2'd0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            rdata <= 32'd0;
            if (!legal_c || misal_c) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= S_REQ;
              st_q      <= is_store;
              f3_q      <= funct3;
              lo_q      <= addr[1:0];
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= is_store ? st_be_c : 4'b1111;
              mem_wdata <= is_store ? st_wdata_c : 32'd0;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt     <= '0;
            if (st_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            state   <= S_DONE;
            done    <= 1'b1;
            err     <= 1'b1;
            rdata   <= 32'd0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            rdata <= load_ext(f3_q, lo_q, mem_rdata);
            state <= S_DONE;
            done  <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
            rdata <= 32'd0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WAIT_LIMIT, default 255: maximum cycles spent in REQ or WAIT before a timeout abort.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  one-cycle request from the core controller; sampled only in IDLE.
REQ-005 is_store  in  1  1 = store (SB/SH/SW), 0 = load (LB/LH/LW/LBU/LHU).
REQ-006 funct3  in  3  IR[14:12] of the memory instruction.
REQ-007 addr  in  32  effective address, i.e. the ALU result rs1+IMM.
REQ-008 wdata  in  32  store source operand (rs2).
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rdata  out  32  extended load result, valid while done=1; held until the next start.
REQ-012 err  out  1  high with done when the access aborted (timeout, illegal funct3, or misalignment when trapping).
REQ-013 mem_req, mem_we  out  1 each  bus request and write enable.
REQ-014 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-015 mem_be  out  4  byte-lane enables.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_gnt, mem_rvalid  in  1 each  request accepted; read data valid.
REQ-018 mem_rdata  in  32  read word.

Function
REQ-019 FSM states are IDLE, REQ, WAIT and DONE; the FSM transitions only on the clk edge.
REQ-020 IDLE with start=1 and a legal access: latch is_store, funct3, addr and wdata, then go to REQ.
REQ-021 Legal funct3 values are 000, 001 and 010 for stores, and 000, 001, 010, 100 and 101 for loads; any other value goes directly to DONE with err=1 and rdata=0, with no bus cycle.
REQ-022 REQ: mem_req=1, and mem_addr, mem_be, mem_we and mem_wdata stay stable until mem_gnt=1; on mem_gnt a store goes to DONE and a load goes to WAIT.
REQ-023 WAIT: mem_req=0; on mem_rvalid=1, capture the extended load data and go to DONE.
REQ-024 DONE: done=1 for exactly one cycle, then return to IDLE; start is ignored in every state except IDLE.
REQ-025 Latency with mem_gnt already high: a store has done high 2 cycles after start; a load with mem_rvalid one cycle after gnt has done high 3 cycles after start.
REQ-026 Byte-lane enables: SB gives mem_be=4'b0001<<addr[1:0] with wdata[7:0] replicated to all 4 lanes; SH gives mem_be=4'b0011<<{addr[1],1'b0} with wdata[15:0] replicated to both halves; SW gives mem_be=4'b1111.
REQ-027 Loads request mem_be=4'b1111; LB/LBU select byte addr[1:0] and LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, and LW passes the word through.
REQ-028 A wait counter resets on entry to REQ and on entry to WAIT, and increments each cycle spent there; when it reaches WAIT_LIMIT, go to DONE with err=1, rdata=0 and mem_req=0.
REQ-029 mem_gnt and mem_rvalid arriving in the same REQ cycle: the gnt is taken and the rvalid is ignored; the bus guarantees rvalid arrives only after gnt.

Reset
REQ-030 rst_n=0 at a clk edge forces IDLE, and sets busy, done, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, rdata and the counter to 0.
REQ-031 Reset asserted mid-transaction abandons the access; mem_req is 0 after that edge and a late mem_rvalid is ignored.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN defined: an SH/LH/LHU access with addr[0]=1, or an SW/LW access with addr[1:0]!=0, performs no bus cycle and goes from IDLE to DONE with err=1 and rdata=0.
REQ-033 Macro LSU_MISALIGN_TRAP_EN undefined: the misaligned low address bits are ignored (a half access uses addr[1], a word access uses mem_be=1111) and the access proceeds normally with err=0.

Verification
REQ-034 SB with addr=0x00000103, wdata=0x000000AB, and gnt held high -> mem_addr=0x00000100, mem_be=1000, mem_wdata=0xABABABAB, done high 2 cycles after start, err=0.
REQ-035 LB with addr=0x00000201, mem_rdata=0x00008000 in the rvalid cycle -> rdata=0xFFFFFF80 (this is rdata=sext(0x80), since byte 1 of 0x00008000 is 0x80); LBU on the same data -> rdata=0x00000080.
REQ-036 LH with addr=0x00000002, mem_rdata=0x8001_1234 -> rdata=0xFFFF8001; LHU on the same data -> rdata=0x00008001.
REQ-037 With mem_gnt held low for WAIT_LIMIT cycles -> done=1 and err=1, mem_req drops, and the next start is accepted normally.
REQ-038 SW with addr=0x00000006: with LSU_MISALIGN_TRAP_EN -> no mem_req, done 1 cycle after start, err=1; without the macro -> mem_addr=0x00000004, mem_be=1111, err=0.
REQ-039 rst_n low during WAIT -> IDLE and all outputs 0 after the edge; an rvalid afterwards produces no done pulse.
